img_seq_read_ctrl: RTL and testbench
====================================

// Module: img_seq_read_ctrl
// PURPOSE
//  Parametrised successor to the single-image sector read controller.
//  - Issues sequential sector-read requests to sd_ctrl for one of IMG_NUM images stored back to back on the card.
//  - Supports single-shot load, manual next-image stepping, and an auto-cycling slideshow with dwell time.
//  - Sits between sd_ctrl (rd_start_en/rd_sec_addr/rd_busy) and the top level, in the clk_50mhz domain.
// PARAMETERS
//  IMG_BASE_ADDR  32'd16640  first sector of image 0
//  IMG_STRIDE     32'd1216   sector distance between consecutive images (>= SECS_PER_IMG)
//  SECS_PER_IMG   1200       sectors per image (640x480x16b / 512B)
//  IMG_NUM        4          number of images (>= 1); index wraps IMG_NUM-1 -> 0
//  HOLD_CYCLES    50000000   auto-mode dwell after an image completes (clk cycles, >= 1)
//  TIMEOUT_CYCLES 1000000    watchdog limit per sector (only with RD_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock (50 MHz domain)
//  rst          in   1   asynchronous, active-high reset
//  init_done    in   1   SD card initialised; low forces/keeps IDLE
//  start        in   1   1-cycle pulse: load current image
//  next_img     in   1   1-cycle pulse: advance index and load
//  mode_auto    in   1   1 = cycle images continuously
//  rd_busy      in   1   sd_ctrl read busy
//  rd_start_en  out  1   1-cycle sector read request
//  rd_sec_addr  out  32  sector address; stable from request until rd_busy falls
//  img_idx      out  IW  current image index, IW = max(1,$clog2(IMG_NUM))
//  busy         out  1   high in any state except IDLE
//  img_done     out  1   1-cycle pulse when the last sector of an image completes
//  err          out  1   sticky watchdog error (tied 0 without RD_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0; img_idx=0; sec_cnt=0; state IDLE.
//  FSM: IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> (ISSUE | DONE); DONE -> (HOLD | IDLE); HOLD -> ISSUE.
//  IDLE:
//   - start: sec_cnt=0, go ISSUE, clear err.
//   - next_img: idx+1 with wrap, sec_cnt=0, go ISSUE.
//   - start and next_img together: next_img wins.
//   - mode_auto=1 with init_done=1 behaves as start.
//  ISSUE (1 cycle):
//   - rd_start_en=1.
//   - rd_sec_addr = IMG_BASE_ADDR + idx*IMG_STRIDE + sec_cnt, 32-bit mod 2^32, registered one cycle earlier.
//  WAIT_HI: wait for rd_busy=1. WAIT_LO: wait for rd_busy=0.
//  On rd_busy fall:
//   - sec_cnt < SECS_PER_IMG-1: sec_cnt+1, go ISSUE. Next request is 1 cycle after busy falls.
//   - otherwise go DONE.
//  DONE (1 cycle):
//   - img_done=1.
//   - mode_auto=1: go HOLD, dwell counter = 0. Else go IDLE; idx is unchanged.
//  HOLD:
//   - Count to HOLD_CYCLES-1, then idx+1 with wrap, sec_cnt=0, go ISSUE.
//   - next_img ends the dwell at once, with the same action.
//   - mode_auto falling: go IDLE.
//  start/next_img pulses outside IDLE/HOLD are ignored (not queued).
//  init_done low in any state: go IDLE next cycle, no img_done. idx kept; sec_cnt=0.
//  Async rst mid-transfer: immediate return to reset values. An in-flight sd_ctrl read is not cancelled.
// CONFIGURATION
//  RD_TIMEOUT_EN defined:
//   - Per-sector watchdog counts in WAIT_HI + WAIT_LO.
//   - At TIMEOUT_CYCLES it sets err=1 (sticky until start/next_img in IDLE, or rst) and goes IDLE, no img_done.
//   - Auto mode then halts until start or next_img.
//  RD_TIMEOUT_EN undefined: no watchdog logic; err is constant 0; WAIT states wait forever.
// TESTING  (bench params: BASE=100, STRIDE=10, SECS=4, IMG_NUM=3, HOLD=20, TIMEOUT=50;
//           sd_ctrl model raises busy 2 cycles after request and holds it 5 cycles)
//  1. start, mode_auto=0 -> 4 requests at addr 100,101,102,103. One img_done after the 4th busy fall. busy drops. img_idx=0.
//  2. next_img x3 from IDLE, each image run to completion -> addrs 110..113, 120..123, then 100..103 (wrap). img_idx 1,2,0.
//  3. mode_auto=1 -> images 0,1,2,0 in turn. 20-cycle gap in HOLD after each img_done. next_img mid-HOLD starts the next image immediately.
//  4. init_done deasserted after 2nd request -> IDLE next cycle, no img_done. A later start re-requests addr 100.
//  5. start and next_img in the same cycle at idx=0 -> first addr 110.
//  6. RD_TIMEOUT_EN, model never raises busy -> err=1 at 50 cycles, IDLE, no img_done. Next start clears err.
//     Without RD_TIMEOUT_EN, err stays 0 and busy stays high.

Source files
------------

// File: rtl/img_seq_read_ctrl.sv
// Sequential sector-read sequencer for IMG_NUM images stored back to back on the SD card.
// Defining RD_TIMEOUT_EN adds a per-sector read watchdog driving the sticky err output.
module img_seq_read_ctrl #(
    parameter logic [31:0] IMG_BASE_ADDR  = 32'd16640,
    parameter logic [31:0] IMG_STRIDE     = 32'd1216,
    parameter int unsigned SECS_PER_IMG   = 1200,
    parameter int unsigned IMG_NUM        = 4,
    parameter int unsigned HOLD_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned IW = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_done,
    input  logic          start,
    input  logic          next_img,
    input  logic          mode_auto,
    input  logic          rd_busy,
    output logic          rd_start_en,
    output logic [31:0]   rd_sec_addr,
    output logic [IW-1:0] img_idx,
    output logic          busy,
    output logic          img_done,
    output logic          err
);

    localparam int unsigned SW = (SECS_PER_IMG > 1) ? $clog2(SECS_PER_IMG) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SEC_LAST  = SW'(SECS_PER_IMG - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(IMG_NUM - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE, HOLD} state_t;

    state_t        state;
    logic [SW-1:0] sec_cnt;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idx_inc;
    logic          timeout_c;

    assign idx_inc = (img_idx == IDX_LAST) ? '0 : img_idx + IW'(1);

    function automatic logic [31:0] sec_addr(input logic [IW-1:0] idx, input logic [SW-1:0] sec);
        return IMG_BASE_ADDR + (32'(idx) * IMG_STRIDE) + 32'(sec);
    endfunction

`ifdef RD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wd_cnt;

    // Cycles spent waiting on the current sector; restarts with every request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == WAIT_HI || state == WAIT_LO)
            wd_cnt <= wd_cnt + TW'(1);
        else
            wd_cnt <= '0;
    end

    // Fires only when the wait would not otherwise make progress this cycle.
    assign timeout_c = (wd_cnt == WD_LAST) &&
                       ((state == WAIT_HI && !rd_busy) || (state == WAIT_LO && rd_busy));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (timeout_c && init_done)
            err <= 1'b1;
        else if (state == IDLE && init_done && (start || next_img))
            err <= 1'b0;
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // Sequencer; rd_start_en/img_done are set on entry to ISSUE/DONE so they align with those states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            hold_cnt    <= '0;
            img_idx     <= '0;
            rd_start_en <= 1'b0;
            rd_sec_addr <= '0;
            busy        <= 1'b0;
            img_done    <= 1'b0;
        end else begin
            rd_start_en <= 1'b0;
            img_done    <= 1'b0;
            if (!init_done) begin
                state   <= IDLE;
                busy    <= 1'b0;
                sec_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (next_img) begin
                            img_idx     <= idx_inc;
                            sec_cnt     <= '0;
                            rd_sec_addr <= sec_addr(idx_inc, '0);
                            rd_start_en <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ISSUE;
                        end else if (start || (mode_auto && !err)) begin
                            sec_cnt     <= '0;
                            rd_sec_addr <= sec_addr(img_idx, '0);
                            rd_start_en <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                    ISSUE: state <= WAIT_HI;
                    WAIT_HI: begin
                        if (rd_busy) begin
                            state <= WAIT_LO;
                        end else if (timeout_c) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            sec_cnt <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (!rd_busy) begin
                            if (sec_cnt != SEC_LAST) begin
                                sec_cnt     <= sec_cnt + SW'(1);
                                rd_sec_addr <= sec_addr(img_idx, sec_cnt + SW'(1));
                                rd_start_en <= 1'b1;
                                state       <= ISSUE;
                            end else begin
                                img_done <= 1'b1;
                                state    <= DONE;
                            end
                        end else if (timeout_c) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            sec_cnt <= '0;
                        end
                    end
                    DONE: begin
                        if (mode_auto) begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (!mode_auto) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (next_img || hold_cnt == HOLD_LAST) begin
                            img_idx     <= idx_inc;
                            sec_cnt     <= '0;
                            rd_sec_addr <= sec_addr(idx_inc, '0);
                            rd_start_en <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_img_seq_read_ctrl.sv
// Bench for img_seq_read_ctrl: directed scenarios with randomized stepping, checked
// against an address/index model derived from the image layout.
module tb_img_seq_read_ctrl;

    localparam logic [31:0] BASE   = 32'd100;
    localparam logic [31:0] STRIDE = 32'd10;
    localparam int SECS = 4;
    localparam int NIMG = 3;
    localparam int HOLD = 20;
    localparam int TMO  = 50;
    localparam int IW   = 2;

    logic clk = 1'b0;
    logic rst, init_done, start, next_img, mode_auto;
    logic rd_busy = 1'b0;
    logic rd_start_en, busy, img_done, err;
    logic [31:0] rd_sec_addr;
    logic [IW-1:0] img_idx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit resp_en = 1'b1;
    logic [31:0] req_addr[$];
    int req_cyc[$];
    int done_cyc[$];
    int m_idx = 0;

    img_seq_read_ctrl #(
        .IMG_BASE_ADDR(BASE), .IMG_STRIDE(STRIDE), .SECS_PER_IMG(SECS),
        .IMG_NUM(NIMG), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .start(start),
        .next_img(next_img), .mode_auto(mode_auto), .rd_busy(rd_busy),
        .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .img_idx(img_idx),
        .busy(busy), .img_done(img_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sd_ctrl model: busy rises 2 cycles after a request and stays high 5 cycles.
    always begin
        @(posedge clk);
        if (rd_start_en && resp_en) begin
            @(posedge clk);
            rd_busy <= 1'b1;
            repeat (5) @(posedge clk);
            rd_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rd_start_en) begin
            req_addr.push_back(rd_sec_addr);
            req_cyc.push_back(cyc);
        end
        if (img_done) done_cyc.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic logic [31:0] exp_addr(input int img, input int s);
        return BASE + STRIDE * 32'(img) + 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input bit do_start, input bit do_next, output int c);
        tick();
        c = cyc;
        start = do_start;
        next_img = do_next;
        tick();
        start = 1'b0;
        next_img = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic expect_img(input string tag, input int rb, input int img);
        for (int s = 0; s < SECS; s++)
            if (rb + s < req_addr.size())
                check(tag, req_addr[rb + s], exp_addr(img, s));
    endtask

    task automatic run_one(input string tag, input bit do_start, input bit do_next);
        int rb, db, c0;
        rb = req_addr.size();
        db = done_cyc.size();
        pulse(do_start, do_next, c0);
        if (do_next) m_idx = (m_idx + 1) % NIMG;
        wait_idle({tag, "_idle"}, 200);
        check({tag, "_nreq"}, 32'(req_addr.size() - rb), 32'(SECS));
        expect_img({tag, "_addr"}, rb, m_idx);
        check({tag, "_ndone"}, 32'(done_cyc.size() - db), 32'd1);
        check({tag, "_idx"}, 32'(img_idx), 32'(m_idx));
        if (rb < req_cyc.size()) check({tag, "_lat"}, 32'(req_cyc[rb]), 32'(c0 + 1));
    endtask

    initial begin
        int c0, rb, db, t, op, k;
        rst = 1'b1; init_done = 1'b0; start = 1'b0; next_img = 1'b0; mode_auto = 1'b0;
        repeat (3) tick();
        check("rst_start_en", 32'(rd_start_en), 32'd0);
        check("rst_addr", rd_sec_addr, 32'd0);
        check("rst_idx", 32'(img_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(img_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        init_done = 1'b1;
        repeat (4) tick();
        check("idle_quiet", 32'(req_addr.size()), 32'd0);

        // Single-shot load of image 0.
        run_one("t1", 1'b1, 1'b0);

        // Three next_img steps wrap back to image 0, then random start/next steps.
        for (int i = 0; i < 3; i++) run_one("t2_next", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) tick();
            run_one("t2_rand", op == 0, op == 1);
        end

        // Auto slideshow over four images with the dwell gap between them.
        rb = req_addr.size();
        db = done_cyc.size();
        mode_auto = 1'b1;
        t = 0;
        while (done_cyc.size() < db + 4 && t < 800) begin
            tick();
            t++;
        end
        mode_auto = 1'b0;
        check("t3_ndone", 32'(done_cyc.size() - db), 32'd4);
        wait_idle("t3_idle", 50);
        check("t3_nreq", 32'(req_addr.size() - rb), 32'(4 * SECS));
        for (int j = 0; j < 4; j++) expect_img("t3_addr", rb + j * SECS, (m_idx + j) % NIMG);
        for (int j = 0; j < 3; j++)
            if (rb + SECS * (j + 1) < req_cyc.size() && db + j < done_cyc.size())
                check("t3_gap", 32'(req_cyc[rb + SECS * (j + 1)] - done_cyc[db + j]), 32'(HOLD + 1));
        m_idx = (m_idx + 3) % NIMG;
        check("t3_idx", 32'(img_idx), 32'(m_idx));

        // next_img in the middle of the dwell starts the following image at once.
        rb = req_addr.size();
        db = done_cyc.size();
        mode_auto = 1'b1;
        t = 0;
        while (done_cyc.size() < db + 1 && t < 200) begin
            tick();
            t++;
        end
        k = int'($urandom_range(3, 10));
        repeat (k) tick();
        pulse(1'b0, 1'b1, c0);
        mode_auto = 1'b0;
        wait_idle("t3n_idle", 200);
        check("t3n_nreq", 32'(req_addr.size() - rb), 32'(2 * SECS));
        expect_img("t3n_addr", rb, m_idx);
        m_idx = (m_idx + 1) % NIMG;
        expect_img("t3n_addr", rb + SECS, m_idx);
        if (rb + SECS < req_cyc.size()) check("t3n_lat", 32'(req_cyc[rb + SECS]), 32'(c0 + 1));
        check("t3n_idx", 32'(img_idx), 32'(m_idx));

        // Asynchronous reset in the middle of a transfer.
        pulse(1'b1, 1'b0, c0);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_idx", 32'(img_idx), 32'd0);
        check("arst_addr", rd_sec_addr, 32'd0);
        check("arst_start_en", 32'(rd_start_en), 32'd0);
        tick();
        rst = 1'b0;
        m_idx = 0;
        repeat (12) tick();

        // init_done drop after the second request aborts without img_done.
        rb = req_addr.size();
        db = done_cyc.size();
        pulse(1'b1, 1'b0, c0);
        t = 0;
        while (req_addr.size() < rb + 2 && t < 50) begin
            tick();
            t++;
        end
        init_done = 1'b0;
        tick();
        check("t4_busy", 32'(busy), 32'd0);
        repeat (12) tick();
        check("t4_nreq", 32'(req_addr.size() - rb), 32'd2);
        check("t4_ndone", 32'(done_cyc.size() - db), 32'd0);
        check("t4_idx", 32'(img_idx), 32'd0);
        init_done = 1'b1;
        run_one("t4_restart", 1'b1, 1'b0);

        // start and next_img together: next_img wins.
        run_one("t5", 1'b1, 1'b1);

        // Sector read that never answers.
        resp_en = 1'b0;
        rb = req_addr.size();
        db = done_cyc.size();
        pulse(1'b1, 1'b0, c0);
`ifdef RD_TIMEOUT_EN
        t = 0;
        while (!err && t < 100) begin
            tick();
            t++;
        end
        check("t6_err", 32'(err), 32'd1);
        check("t6_err_cyc", 32'(cyc - c0), 32'(TMO + 2));
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ndone", 32'(done_cyc.size() - db), 32'd0);
        check("t6_nreq", 32'(req_addr.size() - rb), 32'd1);
        repeat (5) tick();
        check("t6_halt", 32'(req_addr.size() - rb), 32'd1);
        resp_en = 1'b1;
        run_one("t6_restart", 1'b1, 1'b0);
        check("t6_err_clr", 32'(err), 32'd0);
`else
        repeat (80) tick();
        check("t6_err", 32'(err), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_ndone", 32'(done_cyc.size() - db), 32'd0);
        init_done = 1'b0;
        tick();
        check("t6_busy_off", 32'(busy), 32'd0);
        init_done = 1'b1;
        resp_en = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
